// File: rtl/int_to_flop.sv
// int_to_flop: converts a 16-bit two's-complement integer to the 13-bit {sign, mant[7:0], exp[3:0]} float word.
// Latency: 3 + (15 - p) cycles for nonzero input (p = magnitude MSB position), 3 for zero; +1 for nonzero with FLOP_ROUND_EN.
// Backpressure: in_ready is high only in IDLE; the result is held in DONE until out_ready. Optional macro: FLOP_ROUND_EN.
module int_to_flop (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] dout
);

`ifdef FLOP_ROUND_EN
  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ABS, NORM, DONE} state_t;
`endif

  state_t      state;
  logic [15:0] dinReg;
  logic        sign;
  logic [15:0] mag;
  logic [3:0]  exponent;
  logic        outValid;
  logic [12:0] doutReg;

`ifdef FLOP_ROUND_EN
  logic [7:0]  mant;
  logic [8:0]  mantSum;
  logic [7:0]  roundMant;
  logic [3:0]  roundExp;

  // Round half-up on the first discarded bit; a mantissa carry renormalizes into the exponent.
  // p=15 only occurs for mag=16'h8000, whose bit 7 is clear, so the exponent can never wrap.
  always_comb begin
    mantSum   = {1'b0, mant} + {8'd0, mag[7]};
    roundMant = mantSum[7:0];
    roundExp  = exponent;
    if (mantSum[8]) begin
      roundMant = 8'h80;
      roundExp  = exponent + 4'd1;
    end
  end
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = outValid;
  assign dout      = doutReg;

  // Conversion sequencer: accept, take magnitude, shift left until the MSB reaches bit 15, then present.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dinReg   <= 16'd0;
      sign     <= 1'b0;
      mag      <= 16'd0;
      exponent <= 4'd0;
      outValid <= 1'b0;
      doutReg  <= 13'd0;
`ifdef FLOP_ROUND_EN
      mant     <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dinReg <= din;
            sign   <= din[15];
            state  <= ABS;
          end
        end
        ABS: begin
          // -32768 negates to itself, which read as unsigned is exactly 16'h8000.
          mag      <= sign ? (16'd0 - dinReg) : dinReg;
          exponent <= 4'd15;
          state    <= NORM;
        end
        NORM: begin
          if (mag == 16'd0) begin
            sign     <= 1'b0;
            exponent <= 4'd0;
            doutReg  <= 13'd0;
            outValid <= 1'b1;
            state    <= DONE;
`ifdef FLOP_ROUND_EN
            mant     <= 8'd0;
`endif
          end else if (mag[15]) begin
`ifdef FLOP_ROUND_EN
            mant     <= mag[15:8];
            state    <= ROUND;
`else
            doutReg  <= {sign, mag[15:8], exponent};
            outValid <= 1'b1;
            state    <= DONE;
`endif
          end else begin
            mag      <= mag << 1;
            exponent <= exponent - 4'd1;
          end
        end
`ifdef FLOP_ROUND_EN
        ROUND: begin
          mant     <= roundMant;
          exponent <= roundExp;
          doutReg  <= {sign, roundMant, roundExp};
          outValid <= 1'b1;
          state    <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) begin
            outValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
